// File: rtl/serial_slice_comparator.sv
// serial_slice_comparator
//   Slice-serial unsigned magnitude comparator, most-significant slice first.
//   The first unequal slice pair decides the result. If every slice pair is
//   equal, the l/e/g cascade seed latched at start is passed through, so
//   results chain with wider comparisons.
//
// Optional feature macro: SERCMP_EARLY_EXIT_EN
//   Defined: the result is published as soon as a slice pair decides it
//   (state DRAIN). The remaining slices are still consumed and discarded.
//   Undefined: the result is published only after all slices are consumed.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                begin a compare (honoured only in IDLE)
//   l_in, e_in, g_in     cascade seed, sampled on an accepted start
//   in_valid / in_ready  slice handshake (in_ready depends on state only)
//   p_slice, q_slice     operand slices, MSB slice first
//   out_valid/out_ready  result handshake
//   lt, et, gt           registered one-hot result (p<q, p==q, p>q)
//   busy                 high in any state but IDLE
module serial_slice_comparator #(
    parameter int unsigned SLICE_W    = 3,
    parameter int unsigned NUM_SLICES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               l_in,
    input  logic               e_in,
    input  logic               g_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] p_slice,
    input  logic [SLICE_W-1:0] q_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               lt,
    output logic               et,
    output logic               gt,
    output logic               busy
);

    localparam int unsigned CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    // Result/seed encoding is {l, e, g}.
    localparam logic [2:0] RES_LT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b001;

`ifdef SERCMP_EARLY_EXIT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic [2:0]       seed_q, seed_d;
    logic [2:0]       res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
`ifdef SERCMP_EARLY_EXIT_EN
    logic             retired_q, retired_d;
    logic             drained_q, drained_d;
`endif

    logic             accept;
    logic             last_slice;
    logic             differ;
    logic [2:0]       slice_res;

    // Slice-level decision helpers.
    always_comb begin
        accept     = in_valid && in_ready_q;
        last_slice = (cnt_q == LAST_IDX);
        differ     = (p_slice != q_slice);
        slice_res  = (p_slice < q_slice) ? RES_LT : RES_GT;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        seed_d    = seed_q;
        res_d     = res_q;
`ifdef SERCMP_EARLY_EXIT_EN
        retired_d = retired_q;
        drained_d = drained_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d    = {l_in, e_in, g_in};
                    cnt_d     = '0;
                    decided_d = 1'b0;
`ifdef SERCMP_EARLY_EXIT_EN
                    retired_d = 1'b0;
                    drained_d = 1'b0;
`endif
                    state_d   = RUN;
                end
            end

            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Only the most significant differing slice counts.
                    if (!decided_q && differ) begin
                        res_d     = slice_res;
                        decided_d = 1'b1;
                    end
                    if (last_slice) begin
                        if (!decided_q && !differ) begin
                            res_d = seed_q;
                        end
                        state_d = DONE;
                    end
`ifdef SERCMP_EARLY_EXIT_EN
                    else if (!decided_q && differ) begin
                        state_d = DRAIN;
                    end
`endif
                end
            end

`ifdef SERCMP_EARLY_EXIT_EN
            // Result already published; keep swallowing slices. Leave only
            // once both the result has retired and every slice is consumed.
            DRAIN: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        drained_d = 1'b1;
                    end
                end
                if (out_valid_q && out_ready) begin
                    retired_d = 1'b1;
                end
                if (retired_d && drained_d) begin
                    state_d = IDLE;
                end
            end
`endif

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == RUN);
`ifdef SERCMP_EARLY_EXIT_EN
        out_valid_d = out_valid_d || ((state_d == DRAIN) && !retired_d);
        in_ready_d  = in_ready_d  || ((state_d == DRAIN) && !drained_d);
`endif
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            decided_q   <= 1'b0;
            seed_q      <= RES_EQ;
            res_q       <= 3'b000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERCMP_EARLY_EXIT_EN
            retired_q   <= 1'b0;
            drained_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            decided_q   <= decided_d;
            seed_q      <= seed_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef SERCMP_EARLY_EXIT_EN
            retired_q   <= retired_d;
            drained_q   <= drained_d;
`endif
        end
    end

    assign {lt, et, gt} = res_q;
    assign out_valid    = out_valid_q;
    assign in_ready     = in_ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_serial_slice_comparator.sv
// Self-checking bench for serial_slice_comparator: directed cases plus
// randomized operands/throttling checked against a whole-word reference model.
module tb_serial_slice_comparator;

    localparam int unsigned SW = 3;
    localparam int unsigned NS = 3;
    localparam int unsigned W  = SW * NS;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          l_in, e_in, g_in;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] p_slice, q_slice;
    logic          out_valid;
    logic          out_ready;
    logic          lt, et, gt;
    logic          busy;

    logic          rnd_ready;
    logic          rnd_bit;
    logic          ready_force;

    int            n_cmp;
    int            n_fail;
    int            n_pushed;
    int            n_retired;
    logic [2:0]    exp_q[$];
    logic [2:0]    last_res;
    logic [2:0]    held;
    bit            holding;
    longint        t_start;
    longint        t_valid;

    serial_slice_comparator #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .l_in     (l_in),
        .e_in     (e_in),
        .g_in     (g_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p_slice  (p_slice),
        .q_slice  (q_slice),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lt       (lt),
        .et       (et),
        .gt       (gt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign out_ready = rnd_ready ? rnd_bit : ready_force;

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    // Whole-word reference: first differing slice MSB-first == plain compare.
    function automatic logic [2:0] model(input logic [W-1:0] p, input logic [W-1:0] q,
                                         input logic [2:0] seed);
        if (p < q) return 3'b100;
        if (p > q) return 3'b001;
        return seed;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Result monitor: every out_valid cycle is checked against the model queue.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            holding = 1'b0;
        end else if (out_valid) begin
            if (!holding) begin
                t_valid = $time - 1;
                check("onehot", 32'($onehot({lt, et, gt})), 32'(1));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_valid: got out_valid=1 required 0");
                end else begin
                    check("result", 32'({lt, et, gt}), 32'(exp_q[0]));
                end
                held = {lt, et, gt};
            end else begin
                check("hold_stable", 32'({lt, et, gt}), 32'(held));
            end
            if (out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                last_res = {lt, et, gt};
                n_retired++;
                holding  = 1'b0;
            end else begin
                holding = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'(0));
    endtask

    // Issue a start and feed nsl slices; returns on the negedge after the
    // last accepting edge.
    task automatic run_cmp(input logic [W-1:0] p, input logic [W-1:0] q,
                           input logic [2:0] seed, input int gap, input bit rnd,
                           input int nsl, input bit push);
        int k;
        int g;
        wait_idle();
        start = 1'b1;
        {l_in, e_in, g_in} = seed;
        t_start = $time;
        if (push) begin
            exp_q.push_back(model(p, q, seed));
            n_pushed++;
        end
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < nsl; s++) begin
            g = rnd ? int'($urandom_range(0, 3)) : ((s == 0) ? 0 : gap);
            repeat (g) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            p_slice  = p[(NS-1-s)*SW +: SW];
            q_slice  = q[(NS-1-s)*SW +: SW];
            k = 0;
            while (!in_ready && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_fail++;
                $display("FAIL slice_timeout: got in_ready=0 required 1");
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rp, rq;
        logic [2:0]   rs;
        n_cmp = 0; n_fail = 0; n_pushed = 0; n_retired = 0;
        holding = 1'b0; held = 3'b000; last_res = 3'b000;
        t_start = 0; t_valid = 0;
        rst_n = 1'b0; start = 1'b0; {l_in, e_in, g_in} = 3'b010;
        in_valid = 1'b0; p_slice = '0; q_slice = '0;
        rnd_ready = 1'b0; ready_force = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({in_ready, out_valid, lt, et, gt, busy}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Equal operands, seed e: result e, best-case latency, busy drops next cycle.
        run_cmp(9'o444, 9'o444, 3'b010, 0, 0, NS, 1);
        check("eq_valid_now", 32'(out_valid), 32'(1));
        @(negedge clk);
        check("eq_busy_low", 32'(busy), 32'(0));
        check("eq_result", 32'(last_res), 32'(3'b010));
        check("eq_latency", 32'((t_valid - t_start) / 10), 32'(4));

        // Equal operands, seed l.
        run_cmp(9'o444, 9'o444, 3'b100, 0, 0, NS, 1);
        wait_idle();
        check("eq_seed_l", 32'(last_res), 32'(3'b100));

        // Decided on the MSB slice.
        run_cmp(9'o700, 9'o677, 3'b010, 0, 0, NS, 1);
`ifdef SERCMP_EARLY_EXIT_EN
        check("gt_busy_after_drain", 32'(busy), 32'(0));
        wait_idle();
        check("gt_latency", 32'((t_valid - t_start) / 10), 32'(2));
`else
        check("gt_valid_now", 32'(out_valid), 32'(1));
        wait_idle();
        check("gt_latency", 32'((t_valid - t_start) / 10), 32'(4));
`endif
        check("gt_result", 32'(last_res), 32'(3'b001));

        // Decided on the last slice, 2 idle cycles between slices.
        run_cmp(9'o123, 9'o124, 3'b010, 2, 0, NS, 1);
        wait_idle();
        check("lt_gap_result", 32'(last_res), 32'(3'b100));
        check("lt_gap_latency", 32'((t_valid - t_start) / 10), 32'(8));

        // Back-pressure: result held 5 cycles, start during hold and on retire ignored.
        ready_force = 1'b0;
        run_cmp(9'o555, 9'o556, 3'b001, 0, 0, NS, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_value", 32'({lt, et, gt}), 32'(3'b100));
            start = (i == 2);
            @(negedge clk);
        end
        ready_force = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("retire_start_ignored", 32'({busy, in_ready}), 32'(0));
        @(negedge clk);
        check("still_idle", 32'(busy), 32'(0));

        // Reset after 2 slices, then a fresh compare.
        run_cmp(9'o777, 9'o000, 3'b010, 0, 0, 2, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({in_ready, out_valid, lt, et, gt, busy}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmp(9'o010, 9'o001, 3'b010, 0, 0, NS, 1);
        wait_idle();
        check("post_reset_gt", 32'(last_res), 32'(3'b001));

        // Randomized back-to-back compares with throttling on both sides.
        rnd_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            rp = W'($urandom);
            rq = ($urandom_range(0, 3) == 0) ? rp : W'($urandom);
            rs = 3'(3'b001 << $urandom_range(0, 2));
            run_cmp(rp, rq, rs, 0, 1, NS, 1);
        end
        wait_idle();
        rnd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("retired_count", 32'(n_retired), 32'(n_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
